// File: rtl/smm_seq_ctrl.sv
// smm_seq_ctrl: sequencer for the Strassen multiply datapath. It loads the T/S
//   operand sums, issues products M1..M7 in lane-sized batches, waits M_LAT cycles
//   per batch, triggers the C combine and streams OUT_BEATS result beats.
// Latency: with out_ready held high, start at cycle t gives done at
//   t+2+NB*(1+M_LAT)+1+OUT_BEATS.
// Backpressure: out_ready low holds WRITE_OUT with out_beat stable, for as long as it stays low.
// Ports: clk/rst (async, active-high); start/abort from the scheduler;
//   out_ready from downstream; busy/done handshake; load_ts/issue_m/compute_c
//   one-cycle strobes; m_base/m_mask describe the batch in flight;
//   out_valid/out_beat carry the output stream.
module smm_seq_ctrl #(
    parameter int LANES     = 1,
    parameter int M_LAT     = 4,
    parameter int OUT_BEATS = 4,
    localparam int BEAT_W   = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              busy,
    output logic              load_ts,
    output logic              issue_m,
    output logic [2:0]        m_base,
    output logic [LANES-1:0]  m_mask,
    output logic              compute_c,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_beat,
    output logic              done
);

    localparam int NB     = (7 + LANES - 1) / LANES;
    localparam int WAIT_W = (M_LAT > 1) ? $clog2(M_LAT) : 1;

    localparam logic [2:0]        LAST_BATCH = 3'(NB - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(M_LAT - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(OUT_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_TS,
        S_ISSUE_M,
        S_WAIT_M,
        S_COMPUTE_C,
        S_WRITE_OUT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          batch, batch_nxt;
    logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
    logic [BEAT_W-1:0]   beat, beat_nxt;
    logic [2:0]          base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            batch <= '0;
            wcnt  <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            batch <= batch_nxt;
            wcnt  <= wcnt_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        batch_nxt = batch;
        wcnt_nxt  = wcnt;
        beat_nxt  = beat;

        busy      = (state != S_IDLE);
        load_ts   = 1'b0;
        issue_m   = 1'b0;
        m_base    = '0;
        m_mask    = '0;
        compute_c = 1'b0;
        out_valid = 1'b0;
        out_beat  = '0;
        done      = 1'b0;

        // batch*LANES never exceeds 6 for a legal batch index
        base = 3'(int'(batch) * LANES);

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD_TS;
            end
            S_LOAD_TS: begin
                load_ts   = 1'b1;
                batch_nxt = '0;
                state_nxt = S_ISSUE_M;
            end
            S_ISSUE_M: begin
                issue_m   = 1'b1;
                wcnt_nxt  = '0;
                state_nxt = S_WAIT_M;
            end
            S_WAIT_M: begin
                if (wcnt == LAST_WAIT) begin
                    if (batch != LAST_BATCH) begin
                        batch_nxt = batch + 3'd1;
                        state_nxt = S_ISSUE_M;
                    end else begin
                        state_nxt = S_COMPUTE_C;
                    end
                end else begin
                    wcnt_nxt = wcnt + WAIT_W'(1);
                end
            end
            S_COMPUTE_C: begin
                compute_c = 1'b1;
                beat_nxt  = '0;
                state_nxt = S_WRITE_OUT;
            end
            S_WRITE_OUT: begin
                out_valid = 1'b1;
                out_beat  = beat;
                if (out_ready) begin
                    if (beat == LAST_BEAT) state_nxt = S_DONE;
                    else                   beat_nxt  = beat + BEAT_W'(1);
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Batch descriptor stays visible for the whole issue + wait window.
        if (state == S_ISSUE_M || state == S_WAIT_M) begin
            m_base = base;
            for (int i = 0; i < LANES; i++) begin
                m_mask[i] = (int'(base) + i) < 7;
            end
        end

        // abort wins over every other transition, including the final beat
        if (abort && state != S_IDLE) state_nxt = S_IDLE;

        // Counters always restart from zero whenever the sequencer idles.
        if (state_nxt == S_IDLE) begin
            batch_nxt = '0;
            wcnt_nxt  = '0;
            beat_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_smm_seq_ctrl.sv
// tb_smm_seq_ctrl: drives three sequencer instances (LANES = 1, 4, 7) and checks
//   every output on every cycle against a cycle-offset model of one operation,
//   plus directed timing expectations computed by hand.
module tb_smm_seq_ctrl;

    localparam int M_LAT     = 4;
    localparam int OUT_BEATS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] abort = '0;
    logic [2:0] out_ready = '1;

    logic [2:0] busy, load_ts, issue_m, compute_c, out_valid, done;
    logic [2:0] m_base0, m_base1, m_base2;
    logic [1:0] beat0, beat1, beat2;
    logic [0:0] mask0;
    logic [3:0] mask1;
    logic [6:0] mask2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    smm_seq_ctrl #(.LANES(1), .M_LAT(M_LAT), .OUT_BEATS(OUT_BEATS)) u_l1 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .load_ts(load_ts[0]), .issue_m(issue_m[0]), .m_base(m_base0),
        .m_mask(mask0), .compute_c(compute_c[0]), .out_valid(out_valid[0]),
        .out_beat(beat0), .done(done[0]));

    smm_seq_ctrl #(.LANES(4), .M_LAT(M_LAT), .OUT_BEATS(OUT_BEATS)) u_l4 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .load_ts(load_ts[1]), .issue_m(issue_m[1]), .m_base(m_base1),
        .m_mask(mask1), .compute_c(compute_c[1]), .out_valid(out_valid[1]),
        .out_beat(beat1), .done(done[1]));

    smm_seq_ctrl #(.LANES(7), .M_LAT(M_LAT), .OUT_BEATS(OUT_BEATS)) u_l7 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .out_ready(out_ready[2]),
        .busy(busy[2]), .load_ts(load_ts[2]), .issue_m(issue_m[2]), .m_base(m_base2),
        .m_mask(mask2), .compute_c(compute_c[2]), .out_valid(out_valid[2]),
        .out_beat(beat2), .done(done[2]));

    // model state per instance: active flag, cycles since start, beats transferred
    int  lanes_of[3] = '{1, 4, 7};
    bit  m_act[3];
    int  m_k[3];
    int  m_x[3];

    // observations used by the directed checks
    int         done_cyc[3], done_cnt[3], load_cyc[3], load_cnt[3];
    int         cc_cyc[3], cc_cnt[3], issue_cnt[3];
    logic [2:0] last_base[3];
    logic [6:0] last_mask[3];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] act_base(input int d);
        case (d)
            0:       return m_base0;
            1:       return m_base1;
            default: return m_base2;
        endcase
    endfunction

    function automatic logic [6:0] act_mask(input int d);
        case (d)
            0:       return {6'b0, mask0};
            1:       return {3'b0, mask1};
            default: return mask2;
        endcase
    endfunction

    function automatic logic [1:0] act_beat(input int d);
        case (d)
            0:       return beat0;
            1:       return beat1;
            default: return beat2;
        endcase
    endfunction

    // Expected outputs follow from the offset k into an operation: k=1 load,
    // then NB slots of (1 issue + M_LAT wait), one combine cycle, then beats
    // paced by out_ready, then a done cycle.
    task automatic model_step(input int d);
        int L, nb, iss_end, w, j, e_base, e_beat;
        logic e_busy, e_load, e_iss, e_cc, e_ov, e_done;
        logic [6:0] e_mask;
        L       = lanes_of[d];
        nb      = (7 + L - 1) / L;
        iss_end = 2 + nb * (1 + M_LAT);
        w       = iss_end + 1;
        if (rst) m_act[d] = 1'b0;

        e_busy = m_act[d];
        e_load = m_act[d] && m_k[d] == 1;
        e_iss  = 1'b0;
        e_base = 0;
        e_mask = '0;
        if (m_act[d] && m_k[d] >= 2 && m_k[d] < iss_end) begin
            j      = m_k[d] - 2;
            e_iss  = (j % (1 + M_LAT)) == 0;
            e_base = (j / (1 + M_LAT)) * L;
            for (int i = 0; i < L; i++) if (e_base + i < 7) e_mask[i] = 1'b1;
        end
        e_cc   = m_act[d] && m_k[d] == iss_end;
        e_ov   = m_act[d] && m_k[d] >= w && m_x[d] < OUT_BEATS;
        e_beat = e_ov ? m_x[d] : 0;
        e_done = m_act[d] && m_k[d] >= w && m_x[d] == OUT_BEATS;

        chk("busy",      d, busy[d],      e_busy);
        chk("load_ts",   d, load_ts[d],   e_load);
        chk("issue_m",   d, issue_m[d],   e_iss);
        chk("m_base",    d, act_base(d),  e_base);
        chk("m_mask",    d, act_mask(d),  e_mask);
        chk("compute_c", d, compute_c[d], e_cc);
        chk("out_valid", d, out_valid[d], e_ov);
        chk("out_beat",  d, act_beat(d),  e_beat);
        chk("done",      d, done[d],      e_done);

        if (load_ts[d])   begin load_cnt[d]++; load_cyc[d] = cyc; end
        if (issue_m[d])   begin issue_cnt[d]++; last_base[d] = act_base(d); last_mask[d] = act_mask(d); end
        if (compute_c[d]) begin cc_cnt[d]++; cc_cyc[d] = cyc; end
        if (done[d])      begin done_cnt[d]++; done_cyc[d] = cyc; end

        // advance to the state after the coming clock edge
        if (rst) begin
            m_act[d] = 1'b0;
        end else if (!m_act[d]) begin
            if (start[d]) begin
                m_act[d] = 1'b1;
                m_k[d]   = 1;
                m_x[d]   = 0;
            end
        end else if (abort[d] || e_done) begin
            m_act[d] = 1'b0;
        end else begin
            if (e_ov && out_ready[d]) m_x[d]++;
            m_k[d]++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int t, snap_a, snap_b;
        tick(3);
        chk("reset_outputs", 0, {busy, load_ts, issue_m, compute_c, out_valid, done}, 0);
        rst = 1'b0;
        tick(2);

        // all three lane configurations, out_ready high throughout
        t = cyc;
        start = 3'b111;
        tick(1);
        start = 3'b000;
        tick(45);
        chk("l1_load_at",    0, load_cyc[0] - t, 1);
        chk("l1_compute_at", 0, cc_cyc[0] - t,   37);
        chk("l1_done_at",    0, done_cyc[0] - t, 42);
        chk("l1_issues",     0, issue_cnt[0],    7);
        chk("l1_last_base",  0, last_base[0],    6);
        chk("l4_done_at",    1, done_cyc[1] - t, 17);
        chk("l4_issues",     1, issue_cnt[1],    2);
        chk("l4_last_base",  1, last_base[1],    4);
        chk("l4_last_mask",  1, last_mask[1],    7'h07);
        chk("l7_done_at",    2, done_cyc[2] - t, 12);
        chk("l7_last_mask",  2, last_mask[2],    7'h7f);

        // backpressure: three stalled cycles on beat 2
        t = cyc;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(39);
        out_ready[0] = 1'b0;
        tick(2);
        chk("stall_valid", 0, out_valid[0], 1);
        chk("stall_beat",  0, beat0,        2);
        tick(1);
        out_ready[0] = 1'b1;
        tick(6);
        chk("bp_done_at", 0, done_cyc[0] - t, 45);

        // abort in the third WAIT_M, then a clean rerun
        snap_a = cc_cnt[0];
        snap_b = done_cnt[0];
        t = cyc;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(13);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        chk("abort_busy", 0, busy[0], 0);
        tick(40);
        chk("abort_no_compute", 0, cc_cnt[0] - snap_a,   0);
        chk("abort_no_done",    0, done_cnt[0] - snap_b, 0);
        t = cyc;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(45);
        chk("rerun_done_at", 0, done_cyc[0] - t, 42);

        // start pulsed during WRITE_OUT is dropped
        snap_a = load_cnt[0];
        snap_b = done_cnt[0];
        t = cyc;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(38);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(10);
        chk("busy_start_loads", 0, load_cnt[0] - snap_a, 1);
        chk("busy_start_dones", 0, done_cnt[0] - snap_b, 1);

        // start held high: back-to-back operations on the 7-lane instance
        snap_a = load_cnt[2];
        t = cyc;
        start[2] = 1'b1;
        tick(25);
        start[2] = 1'b0;
        tick(3);
        chk("b2b_second_load", 2, load_cyc[2] - t,      14);
        chk("b2b_second_done", 2, done_cyc[2] - t,      25);
        chk("b2b_loads",       2, load_cnt[2] - snap_a, 2);
        chk("b2b_idle",        2, busy[2],              0);

        // asynchronous reset between edges during WAIT_M
        snap_a = load_cnt[0];
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(3);
        chk("pre_rst_busy", 0, busy[0], 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 0,
            {busy[0], load_ts[0], issue_m[0], m_base0, mask0, compute_c[0], out_valid[0], beat0, done[0]}, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("post_rst_idle",  0, busy[0],              0);
        chk("post_rst_loads", 0, load_cnt[0] - snap_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
